// File: rtl/d_flip_flop_reg.sv
// d_flip_flop_reg: parameterized multi-stage D register with clock enable,
// synchronous clear and a per-stage valid flag. It is the generic data-holding
// and retiming stage placed between datapath blocks.
//
// Build option: define DFF_PARITY_EN to add d_par_out. It is a parity bit that
// travels alongside the data through every stage, so d_par_out == ^d_out holds
// on every cycle after the first edge.
//
// Priority at each rising clk edge: rst > clr > en > hold.
// rst and clr both load RESET_VAL into every stage and clear every valid flag.
// The output always comes from a register, so there is no combinational path
// from d_in to d_out.
module d_flip_flop_reg #(
  parameter int          WDT       = 4,
  parameter int unsigned RESET_VAL = 0,
  parameter int          DEPTH     = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           clr,
  input  logic [WDT-1:0] d_in,
  output logic [WDT-1:0] d_out,
  output logic           vld_out
`ifdef DFF_PARITY_EN
  ,
  output logic           d_par_out
`endif
);

  // Reset constant narrowed or zero-extended to the datapath width.
  localparam logic [WDT-1:0] L_RESET_VAL = WDT'(RESET_VAL);

  // Refuse to elaborate a degenerate register.
  generate
    if (DEPTH < 1 || WDT < 1) begin : g_bad_param
      $error("d_flip_flop_reg: DEPTH and WDT must both be >= 1");
    end
  endgenerate

  // rst and clr have the same effect on state. Merging them here keeps every
  // stage's update logic identical.
  logic w_flush;
  assign w_flush = rst | clr;

  // Pipeline state. Element 0 is nearest d_in and element DEPTH-1 drives d_out.
  logic [WDT-1:0] r_stage   [DEPTH];
  logic           r_vld     [DEPTH];
  logic [WDT-1:0] w_stage_d [DEPTH];
  logic           w_vld_d   [DEPTH];

`ifdef DFF_PARITY_EN
  // The parity of the reset constant is what a flushed stage must report.
  localparam logic L_RESET_PAR = ^L_RESET_VAL;

  logic r_par   [DEPTH];
  logic w_par_d [DEPTH];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      // Stage input: d_in for the first stage, otherwise the previous stage.
      if (gi == 0) begin : g_head
        assign w_stage_d[gi] = d_in;
        assign w_vld_d[gi]   = 1'b1;
`ifdef DFF_PARITY_EN
        assign w_par_d[gi]   = ^d_in;
`endif
      end else begin : g_body
        assign w_stage_d[gi] = r_stage[gi-1];
        assign w_vld_d[gi]   = r_vld[gi-1];
`ifdef DFF_PARITY_EN
        assign w_par_d[gi]   = r_par[gi-1];
`endif
      end

      // Stage register: on flush load the reset constant, otherwise advance
      // when enabled and hold when not. A stall freezes every stage together,
      // so no bubble is created and no data is lost.
      always_ff @(posedge clk) begin
        if (w_flush) begin
          r_stage[gi] <= L_RESET_VAL;
          r_vld[gi]   <= 1'b0;
        end else if (en) begin
          r_stage[gi] <= w_stage_d[gi];
          r_vld[gi]   <= w_vld_d[gi];
        end
      end

`ifdef DFF_PARITY_EN
      // Parity register follows exactly the same flush/advance/hold rules as
      // the data register beside it.
      always_ff @(posedge clk) begin
        if (w_flush) begin
          r_par[gi] <= L_RESET_PAR;
        end else if (en) begin
          r_par[gi] <= w_par_d[gi];
        end
      end
`endif
    end
  endgenerate

  assign d_out   = r_stage[DEPTH-1];
  assign vld_out = r_vld[DEPTH-1];
`ifdef DFF_PARITY_EN
  assign d_par_out = r_par[DEPTH-1];
`endif

endmodule

// File: tb/tb_d_flip_flop_reg.sv
// Testbench for d_flip_flop_reg. It drives four instances:
//   DUT 0: RESET_VAL=0, DEPTH=1
//   DUT 1: RESET_VAL=A, DEPTH=1
//   DUT 2: RESET_VAL=6, DEPTH=3
//   DUT 3: RESET_VAL=1, DEPTH=1 (parity case)
// The stimulus process pushes hand-computed expected values into a scoreboard
// queue. A separate monitor pops each entry on the following falling edge and
// compares it with the outputs of the selected DUT.
module tb_d_flip_flop_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a [4];
  logic       clr_a [4];
  logic       en_a  [4];
  logic [3:0] din_a [4];
  logic [3:0] dout_w[4];
  logic       vld_w [4];
  logic       par_w [4];

  d_flip_flop_reg #(.WDT(4), .RESET_VAL(0), .DEPTH(1)) u_dut0 (
    .clk(clk), .rst(rst_a[0]), .en(en_a[0]), .clr(clr_a[0]),
    .d_in(din_a[0]), .d_out(dout_w[0]), .vld_out(vld_w[0])
`ifdef DFF_PARITY_EN
    , .d_par_out(par_w[0])
`endif
  );
  d_flip_flop_reg #(.WDT(4), .RESET_VAL(4'hA), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst_a[1]), .en(en_a[1]), .clr(clr_a[1]),
    .d_in(din_a[1]), .d_out(dout_w[1]), .vld_out(vld_w[1])
`ifdef DFF_PARITY_EN
    , .d_par_out(par_w[1])
`endif
  );
  d_flip_flop_reg #(.WDT(4), .RESET_VAL(4'h6), .DEPTH(3)) u_dut2 (
    .clk(clk), .rst(rst_a[2]), .en(en_a[2]), .clr(clr_a[2]),
    .d_in(din_a[2]), .d_out(dout_w[2]), .vld_out(vld_w[2])
`ifdef DFF_PARITY_EN
    , .d_par_out(par_w[2])
`endif
  );
  d_flip_flop_reg #(.WDT(4), .RESET_VAL(4'h1), .DEPTH(1)) u_dut3 (
    .clk(clk), .rst(rst_a[3]), .en(en_a[3]), .clr(clr_a[3]),
    .d_in(din_a[3]), .d_out(dout_w[3]), .vld_out(vld_w[3])
`ifdef DFF_PARITY_EN
    , .d_par_out(par_w[3])
`endif
  );

`ifndef DFF_PARITY_EN
  // Without the option there is no parity port; tie the bench copies off.
  initial begin
    for (int i = 0; i < 4; i++) par_w[i] = 1'b0;
  end
`endif

  typedef struct {
    int         k;
    logic [3:0] d;
    logic       v;
    logic       p;
    int         n;
  } exp_t;

  exp_t sb_q[$];
  int   tests    = 0;
  int   failures = 0;
  int   step_num = 0;

  // Apply one cycle of inputs to DUT k. After the edge, queue the output
  // expected from that DUT. Expected parity is derived from the expected data.
  task automatic step(input int k, input logic r, input logic c, input logic e,
                      input logic [3:0] d, input logic [3:0] xd, input logic xv);
    exp_t x;
    rst_a[k] = r;
    clr_a[k] = c;
    en_a[k]  = e;
    din_a[k] = d;
    @(posedge clk);
    x.k = k;
    x.d = xd;
    x.v = xv;
    x.p = ^xd;
    x.n = step_num;
    sb_q.push_back(x);
    step_num++;
    #1;
  endtask

  // Monitor: one falling-edge sample per queued transaction.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t x;
      x = sb_q.pop_front();
      tests++;
      if (dout_w[x.k] !== x.d) begin
        failures++;
        $display("FAIL d_out dut%0d step%0d: got %h expected %h", x.k, x.n, dout_w[x.k], x.d);
      end
      tests++;
      if (vld_w[x.k] !== x.v) begin
        failures++;
        $display("FAIL vld_out dut%0d step%0d: got %b expected %b", x.k, x.n, vld_w[x.k], x.v);
      end
`ifdef DFF_PARITY_EN
      tests++;
      if (par_w[x.k] !== x.p) begin
        failures++;
        $display("FAIL d_par_out dut%0d step%0d: got %b expected %b", x.k, x.n, par_w[x.k], x.p);
      end
`endif
      $display("[TB] dut%0d step%0d d_out=%h vld_out=%b par=%b", x.k, x.n, dout_w[x.k], vld_w[x.k], par_w[x.k]);
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_a[i] = 1'b1;
      clr_a[i] = 1'b0;
      en_a[i]  = 1'b1;
      din_a[i] = 4'h0;
    end

    // DUT 0 (RESET_VAL=0, DEPTH=1): basic capture, hold, and clear.
    //      k  rst clr en  d_in   d_out  vld
    step(0, 1, 0, 1, 4'h0, 4'h0, 0);
    step(0, 0, 0, 1, 4'h2, 4'h2, 1);
    step(0, 0, 0, 1, 4'h0, 4'h0, 1);
    step(0, 0, 0, 0, 4'h5, 4'h0, 1);   // en low: hold
    step(0, 0, 0, 1, 4'hF, 4'hF, 1);
    step(0, 0, 1, 1, 4'h3, 4'h0, 0);   // clr beats en

    // DUT 1 (RESET_VAL=A, DEPTH=1): rst has priority over d_in.
    step(1, 1, 0, 1, 4'h5, 4'hA, 0);
    step(1, 0, 0, 1, 4'h5, 4'h5, 1);
    step(1, 1, 1, 1, 4'h3, 4'hA, 0);   // rst and clr together
    step(1, 0, 0, 1, 4'h7, 4'h7, 1);
    step(1, 0, 1, 0, 4'h1, 4'hA, 0);   // clr acts even with en low

    // DUT 2 (RESET_VAL=6, DEPTH=3): latency, stall, and mid-stream flush.
    step(2, 1, 0, 1, 4'h0, 4'h6, 0);
    step(2, 0, 0, 1, 4'h1, 4'h6, 0);
    step(2, 0, 0, 1, 4'h2, 4'h6, 0);
    step(2, 0, 0, 1, 4'h3, 4'h1, 1);   // third enabled edge
    step(2, 0, 0, 1, 4'h4, 4'h2, 1);
    step(2, 0, 0, 1, 4'h5, 4'h3, 1);
    step(2, 0, 0, 1, 4'h7, 4'h4, 1);   // load 7
    step(2, 0, 0, 0, 4'h0, 4'h4, 1);   // stall
    step(2, 0, 0, 0, 4'h0, 4'h4, 1);   // stall
    step(2, 0, 0, 1, 4'h8, 4'h5, 1);
    step(2, 0, 0, 1, 4'h9, 4'h7, 1);   // 7 after 3 enabled edges
    step(2, 0, 1, 1, 4'hF, 4'h6, 0);   // clr mid-stream
    step(2, 0, 0, 0, 4'h1, 4'h6, 0);   // stall while empty
    step(2, 0, 0, 1, 4'h1, 4'h6, 0);
    step(2, 0, 0, 1, 4'h2, 4'h6, 0);
    step(2, 0, 0, 1, 4'h3, 4'h1, 1);
    step(2, 1, 1, 1, 4'hF, 4'h6, 0);   // rst and clr together
    step(2, 0, 0, 1, 4'hC, 4'h6, 0);
    step(2, 1, 0, 0, 4'h0, 4'h6, 0);   // rst with en low discards in-flight C

    // DUT 3 (RESET_VAL=1, DEPTH=1): parity cases.
    step(3, 1, 0, 1, 4'h0, 4'h1, 0);
    step(3, 0, 0, 1, 4'h7, 4'h7, 1);
    step(3, 0, 0, 1, 4'h3, 4'h3, 1);

    @(negedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d entries left expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
